// File: rtl/nanci_mem_responder.sv
// Far-end Nanci responder: queues {is_write, addr, data} requests in order and
// services them against a local word memory, returning read results as packets.
module nanci_mem_responder #(
  parameter  int N          = 1024,
  parameter  int I          = 0,
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = (N == 1024) ? 10 : (N == 256) ? 8 : (N == 64) ? 6 :
                              (N == 16) ? 4 : 2,
  localparam int PW         = ADDR_WIDTH + DATA_WIDTH + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [PW-1:0] req_packet,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [PW-1:0] resp_packet,
  output logic [15:0]   write_count,
  output logic          busy
);

  localparam int MIDX = $clog2(MEM_DEPTH);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;

  if (I < 0 || I >= N) begin : g_bad_index
    $error("node index out of range");
  end
  if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || MEM_DEPTH < 2 || MIDX > ADDR_WIDTH) begin : g_bad_mem
    $error("MEM_DEPTH must be a power of 2 within the address space");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [PW-1:0]         fifo [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem  [MEM_DEPTH];
  logic [PTRW-1:0]       wr_ptr, rd_ptr;
  logic [CNTW-1:0]       count;

  logic                  full, empty, push, pop;
  logic [PW-1:0]         head;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [MIDX-1:0]       head_idx;

  always_comb begin
    full       = (count == CNTW'(FIFO_DEPTH));
    empty      = (count == '0);
    // Readiness tracks occupancy only; a full FIFO refuses even on a popping cycle.
    req_ready  = !full;
    push       = req_valid && !full;
    head       = fifo[rd_ptr];
    head_write = head[PW-1];
    head_addr  = head[PW-2:DATA_WIDTH];
    head_data  = head[DATA_WIDTH-1:0];
    head_idx   = head_addr[MIDX-1:0];
    pop        = !empty && (head_write || !resp_valid || resp_ready);
    busy       = !empty || resp_valid;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= req_packet;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[MIDX'(i)] <= '0;
      end
      write_count <= '0;
    end else if (pop && head_write) begin
      mem[head_idx] <= head_data;
      if (write_count != '1) begin
        write_count <= write_count + 16'd1;
      end
    end
  end

  // A read pop reloads the output register even while the previous response is
  // being accepted, so back-to-back reads stream at one per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid  <= 1'b0;
      resp_packet <= '0;
    end else if (pop && !head_write) begin
      resp_valid  <= 1'b1;
      resp_packet <= {1'b0, head_addr, mem[head_idx]};
    end else if (resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nanci_mem_responder.sv
// Randomized scoreboard bench for nanci_mem_responder: a request-level memory
// model predicts read results, a negedge monitor checks every accepted response.
module tb_nanci_mem_responder;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int PW   = AW + DW + 1;
  localparam int MD   = 16;
  localparam int MIDX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_packet;
  logic          resp_valid;
  logic          resp_ready;
  logic [PW-1:0] resp_packet;
  logic [15:0]   write_count;
  logic          busy;

  nanci_mem_responder #(
    .N(1024), .I(0), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_packet(req_packet), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_packet(resp_packet), .write_count(write_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            hs_count = 0;
  int            rdy_mode = 0;
  logic [PW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [MD];
  int            wc_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MD; i++) mem_m[i] = '0;
    wc_m = 0;
    exp_q.delete();
  endtask

  // Called and returns at posedge+1; model is updated in request order on acceptance.
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    logic [MIDX-1:0] idx;
    acc = 1'b0;
    req_valid = 1'b1;
    req_packet = {w, a, d};
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      chk("push_timeout", 64'(acc), 64'd1);
    end else begin
      idx = a[MIDX-1:0];
      if (w) begin
        mem_m[idx] = d;
        if (wc_m < 65535) wc_m++;
      end else begin
        exp_q.push_back({1'b0, a, mem_m[idx]});
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    logic idle;
    idle = 1'b0;
    rdy_mode = 1;
    resp_ready = 1'b1;
    for (int k = 0; k < 500 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    @(posedge clk);
    #1;
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_wcount"}, 64'(write_count), 64'(wc_m));
    chk({name, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       resp_ready = 1'b0;
        1:       resp_ready = 1'b1;
        default: resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    logic          prev_stall;
    logic [PW-1:0] prev_pkt;
    prev_stall = 1'b0;
    prev_pkt = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(resp_valid), 64'd1);
        chk("hold_packet", 64'(resp_packet), 64'(prev_pkt));
      end
      if (resp_valid && resp_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=%h expected=none", resp_packet);
        end else begin
          chk("resp_packet", 64'(resp_packet), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = resp_valid && !resp_ready;
      prev_pkt = resp_packet;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hs0;
    logic w;
    logic [AW-1:0] a;
    rst = 1'b0;
    req_valid = 1'b0;
    req_packet = '0;
    model_reset();
    step(2);
    rst = 1'b1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_packet", 64'(resp_packet), 64'd0);
    chk("rst_wcount", 64'(write_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);

    // First write: memory/counter update one edge after acceptance, no response.
    rdy_mode = 1;
    push(1'b1, 10'd5, 32'hFFFFFFFF);
    chk("wr_wcount_early", 64'(write_count), 64'd0);
    step(1);
    chk("wr_wcount", 64'(write_count), 64'd1);
    chk("wr_no_resp", 64'(resp_valid), 64'd0);

    // Read-after-write on consecutive cycles.
    hs0 = hs_count;
    push(1'b1, 10'd3, 32'hA5A5A5A5);
    push(1'b0, 10'd3, 32'h0);
    step(1);
    chk("raw_valid", 64'(resp_valid), 64'd1);
    chk("raw_packet", 64'(resp_packet), 64'({1'b0, 10'd3, 32'hA5A5A5A5}));
    step(1);
    chk("raw_valid_drop", 64'(resp_valid), 64'd0);
    chk("raw_one_resp", 64'(hs_count - hs0), 64'd1);
    push(1'b0, 10'd5, 32'h0);

    // Aliasing: upper address bits ignored for indexing, echoed in the response.
    push(1'b1, 10'h3F3, 32'd7);
    push(1'b0, 10'h003, 32'h0);
    drain("alias");

    // Backpressure: five reads with the output stalled fill the FIFO.
    rdy_mode = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 10'(i + 8), 32'h1000 + 32'(i));
    for (int i = 0; i < 5; i++) push(1'b0, 10'(i + 8), 32'h0);
    chk("bp_full", 64'(req_ready), 64'd0);
    step(3);
    chk("bp_still_full", 64'(req_ready), 64'd0);
    chk("bp_valid", 64'(resp_valid), 64'd1);
    hs0 = hs_count;
    rdy_mode = 1;
    resp_ready = 1'b1;
    step(5);
    chk("bp_stream", 64'(hs_count - hs0), 64'd5);
    chk("bp_done", 64'(resp_valid), 64'd0);
    drain("bp");

    // Reset mid-operation discards the pending response and queued requests.
    rdy_mode = 0;
    resp_ready = 1'b0;
    push(1'b0, 10'd3, 32'h0);
    push(1'b1, 10'd4, 32'hDEAD);
    push(1'b1, 10'd6, 32'hBEEF);
    push(1'b0, 10'd4, 32'h0);
    chk("mid_valid", 64'(resp_valid), 64'd1);
    rst = 1'b0;
    model_reset();
    step(1);
    rst = 1'b1;
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_wcount", 64'(write_count), 64'd0);
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) push(1'b0, 10'($urandom_range(0, 1023)), 32'h0);
    drain("mid");

    // Randomized traffic with random output backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      push(w, a, $urandom);
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end
    drain("rand");

    // Saturation of the write counter.
    rdy_mode = 1;
    for (int i = 0; i < 65540; i++) push(1'b1, 10'($urandom_range(0, 1023)), $urandom);
    drain("sat");
    chk("sat_value", 64'(write_count), 64'hFFFF);
    for (int i = 0; i < MD; i++) push(1'b0, 10'(i), 32'h0);
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
